// File: rtl/tinyml_pkg.sv
// Shared definitions for the tinyml vector load/store blocks.
// Holds the store_v state encoding and the DRAM address / length widths.
package tinyml_pkg;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TILE = 2'd1,
        ST_WRITING   = 2'd2,
        ST_DONE      = 2'd3
    } store_state_t;

endpackage

// File: rtl/store_v.sv
// store_v: write-back engine for compute tiles.
// Takes TILE_WIDTH-bit tiles and streams them one byte per cycle into the shared
// memory write port, starting at dram_addr and stopping after `length` elements
// (the tail of a partial last tile is never written).
// Optional feature: define STORE_V_ERR_EN to get a sticky protocol-error flag on err;
// when undefined err is tied low and stray strobes are silently ignored.
module store_v
    import tinyml_pkg::*;
#(
    parameter int  TILE_WIDTH = 256,
    parameter int  DATA_WIDTH = 8,
    localparam int ELEM_COUNT = TILE_WIDTH / DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] dram_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              tile_in,
    input  logic [7:0]        data_in [ELEM_COUNT],
    output logic              tile_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              valid_out,
    output logic              err
);

    localparam int BCNT_W = (ELEM_COUNT > 1) ? $clog2(ELEM_COUNT) : 1;

    // The memory port is byte wide; any other element width is a build error.
    generate
        if (DATA_WIDTH != 8) begin : g_bad_data_width
            $fatal(1, "store_v: DATA_WIDTH must be 8");
        end
        if ((TILE_WIDTH % 8) != 0 || TILE_WIDTH < 8) begin : g_bad_tile_width
            $fatal(1, "store_v: TILE_WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    store_state_t      r_state;
    store_state_t      w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_elems_left;
    logic [BCNT_W-1:0] r_byte_cnt;
    logic [7:0]        r_buf [ELEM_COUNT];
    logic              w_last_elem;
    logic              w_tile_end;

    assign w_last_elem = (r_elems_left == LEN_W'(1));
    assign w_tile_end  = (r_byte_cnt == BCNT_W'(ELEM_COUNT - 1));

    // State register; async reset aborts any transfer on the spot.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded outputs (all outputs come from registers).
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        tile_ready   = 1'b0;
        mem_we       = 1'b0;
        valid_out    = 1'b0;
        mem_addr     = r_addr;
        mem_din      = r_buf[r_byte_cnt];
        case (r_state)
            ST_IDLE: begin
                if (valid_in) begin
                    w_next_state = (length == '0) ? ST_DONE : ST_WAIT_TILE;
                end
            end
            ST_WAIT_TILE: begin
                tile_ready = 1'b1;
                if (tile_in) begin
                    w_next_state = ST_WRITING;
                end
            end
            ST_WRITING: begin
                mem_we = 1'b1;
                // Running out of elements wins over running out of tile bytes.
                if (w_last_elem) begin
                    w_next_state = ST_DONE;
                end else if (w_tile_end) begin
                    w_next_state = ST_WAIT_TILE;
                end
            end
            ST_DONE: begin
                valid_out    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Job registers: address/length latched at start, tile captured in WAIT_TILE,
    // counters stepped once per written byte.
    // NOTE: the tile buffer is reset too, so mem_din reads 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_elems_left <= '0;
            r_byte_cnt   <= '0;
            for (int i = 0; i < ELEM_COUNT; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        r_addr       <= dram_addr;
                        r_elems_left <= length;
                    end
                end
                ST_WAIT_TILE: begin
                    if (tile_in) begin
                        r_buf      <= data_in;
                        r_byte_cnt <= '0;
                    end
                end
                ST_WRITING: begin
                    r_addr       <= r_addr + ADDR_W'(1);
                    r_elems_left <= r_elems_left - LEN_W'(1);
                    r_byte_cnt   <= r_byte_cnt + BCNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef STORE_V_ERR_EN
    logic r_err;

    // Sticky protocol error: a strobe arriving in a state that ignores it.
    // A stray strobe in the same cycle as an accepted start still flags the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((valid_in && r_state != ST_IDLE) ||
                     (tile_in  && r_state != ST_WAIT_TILE)) begin
            r_err <= 1'b1;
        end else if (valid_in && r_state == ST_IDLE) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
